dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the single-cycle core's data-memory port and a multi-cycle main memory. It serves read hits in the same cycle. It stalls the core on read misses (line fill) and on every write (write-through to memory).

Parameters:
IDX_BITS, 4, log2 of line count (16 lines)
OFF_BITS, 2, log2 of words per line (4 words = 16 bytes)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
core_rd  in  1  core load request, level, held while core_stall=1
core_wr  in  1  core store request, level, held while core_stall=1
core_addr  in  32  byte address; bits [1:0] ignored
core_wdata  in  8 x [0:3]  store data; [0]=bits 31:24 (big-endian byte order)
core_rdata  out  8 x [0:3]  load data, same byte order
core_stall  out  1  core must freeze PC/state while high
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  32  word-aligned address; stable while mem_req
mem_wdata  out  32  write data; stable while mem_req
mem_rdata  in  32  read data, valid when mem_ack
mem_ack  in  1  one-cycle pulse; completes current transfer

Behaviour:
- Address split: offset = addr[OFF_BITS+1:2]; index = addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2]; tag = the remaining upper bits. Storage: valid[line], tag[line], data[line][word].
- hit = core_rd/core_wr & valid[index] & tag match. Hit detection and core_rdata are combinational from the arrays.
- If core_rd and core_wr are both high, the write takes priority.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE, read hit: core_stall=0; core_rdata = data[index][offset]; no memory traffic.
- IDLE, read miss: core_stall=1; clear cnt; on the next edge go to FILL.
- IDLE, write: core_stall=1; on the next edge go to WRITE.
- IDLE, no request: core_stall=0; core_rdata = 0.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr = {tag, index, cnt, 2'b00}.
  - On each mem_ack, write mem_rdata into data[index][cnt] and increment cnt.
  - On the ack with cnt = 2^OFF_BITS-1, set valid[index] and tag[index], then go to IDLE.
  - The held request then hits in IDLE, releasing the stall.
  - Read-miss latency = 1 + sum of the four memory transfer times + 1 cycle.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr = {core_addr[31:2], 2'b00}, mem_wdata = packed core_wdata.
  - On mem_ack: if hit, update data[index][offset] with core_wdata. On a miss, leave the cache untouched (no allocate). Go to WDONE.
- WDONE: core_stall=0 for exactly one cycle so the core retires the store; unconditionally return to IDLE.
- core_stall is high in FILL and WRITE.
- mem_req is 0 in IDLE and WDONE. mem_req drops in the cycle after the final ack. mem_ack seen while mem_req=0 is ignored.
- valid[index] stays 0 throughout a fill. A partially filled line is never observed as valid.
- Reset (async): state=IDLE, all valid=0, cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Tag and data arrays are not reset.
- Reset mid-fill: the line stays invalid and the next access misses.
- Reset mid-write: the store is abandoned. Memory must tolerate a dropped request.
- cnt wraps naturally at 2^OFF_BITS. The fill terminates on the last-index ack, never on wrap.

Test Plan:
Memory model returns mem_rdata = mem_addr with 2-cycle ack latency; params at defaults.
1. After reset, read 0x100 -> stall high; mem reads 0x100, 0x104, 0x108, 0x10C in order; then stall low and core_rdata = {00,00,01,00}; total stall 1+4x3+... cycles, checked exactly.
2. Then read 0x108 -> same-cycle hit, stall=0, rdata={00,00,01,08}, mem_req stays 0.
3. Write 0x104 = DEADBEEF -> one mem write (we=1, addr 0x104, wdata DEADBEEF); one WDONE cycle with stall=0; next read 0x104 hits with {DE,AD,BE,EF}.
4. Write 0x400 (miss) -> a single mem write; then read 0x400 misses and fills 0x400..0x40C (no allocate).
5. Read 0x200 after case 1 -> conflict at index 0 and refill; read 0x100 then misses again.
6. Assert rst_b during FILL after 2 acks -> mem_req drops immediately; re-read 0x100 performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Core data port and main-memory port of the direct-mapped data cache.
// Bytes are big-endian: element [0] of a word is bits 31:24.
interface dcache_ctrl_if;
  logic             core_rd;
  logic             core_wr;
  logic [31:0]      core_addr;
  logic [0:3][7:0]  core_wdata;
  logic [0:3][7:0]  core_rdata;
  logic             core_stall;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             mem_ack;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, mem_rdata, mem_ack,
    output core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, mem_rdata, mem_ack,
    input  core_rdata, core_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//
// state | meaning
// IDLE  | serve read hits combinationally; launch fill on read miss or write-through on store
// FILL  | fetch the whole line word by word; line stays invalid until the last ack
// WRITE | write-through of the store; cache word updated on ack only if the line hits
// WDONE | one unstalled cycle so the core retires the store
module dcache_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int OFF_BITS = 2
) (
  input logic         clk,
  input logic         rst_b,
  dcache_ctrl_if.slave bus
);
  localparam int LINES    = 1 << IDX_BITS;
  localparam int WORDS    = 1 << OFF_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t               state;
  logic [OFF_BITS-1:0]  cnt;
  logic [OFF_BITS-1:0]  cnt_nxt;
  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [31:0]          data_mem [LINES][WORDS];

  logic [OFF_BITS-1:0]  off;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 line_hit;
  logic                 rd_req;
  logic                 wr_req;
  logic                 ack;
  logic                 stall;
  logic [31:0]          rdata;
  logic                 unused_addr_bits;

  assign off              = bus.core_addr[OFF_BITS+1:2];
  assign idx              = bus.core_addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
  assign tag              = bus.core_addr[31:IDX_BITS+OFF_BITS+2];
  assign unused_addr_bits = ^bus.core_addr[1:0];

  assign line_hit = valid[idx] && (tag_mem[idx] == tag);
  assign wr_req   = bus.core_wr;
  assign rd_req   = bus.core_rd && !bus.core_wr;
  // an ack with no request outstanding is stale and must not advance anything
  assign ack      = bus.mem_ack && bus.mem_req;
  assign cnt_nxt  = cnt + 1'b1;

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          stall = 1'b1;
        end else if (rd_req) begin
          if (line_hit) rdata = data_mem[idx][off];
          else          stall = 1'b1;
        end
      end
      FILL, WRITE: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  assign bus.core_stall = stall;
  assign bus.core_rdata = rdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      valid         <= '0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            state         <= WRITE;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {bus.core_addr[31:2], 2'b00};
            bus.mem_wdata <= bus.core_wdata;
          end else if (rd_req && !line_hit) begin
            state        <= FILL;
            cnt          <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {bus.core_addr[31:OFF_BITS+2], {OFF_BITS{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (ack) begin
            cnt <= cnt_nxt;
            if (&cnt) begin
              valid[idx]  <= 1'b1;
              state       <= IDLE;
              bus.mem_req <= 1'b0;
            end else begin
              bus.mem_addr <= {bus.core_addr[31:OFF_BITS+2], cnt_nxt, 2'b00};
            end
          end
        end
        WRITE: begin
          if (ack) begin
            state       <= WDONE;
            bus.mem_req <= 1'b0;
          end
        end
        WDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // tag and data storage carry no reset; valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (state == FILL && ack) begin
      data_mem[idx][cnt] <= bus.mem_rdata;
      if (&cnt) tag_mem[idx] <= tag;
    end
    if (state == WRITE && ack && line_hit) begin
      data_mem[idx][off] <= bus.core_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl; memory answers mem_rdata = mem_addr,
// each transfer taking three cycles of mem_req (ack in the third).
module tb_dcache_ctrl;
  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wdata[$];

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model
  initial begin
    int wc;
    wc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wc = bus.mem_req ? 1 : 0;
      end else if (bus.mem_req) begin
        wc++;
        if (wc == 3) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr;
          log_addr.push_back(bus.mem_addr);
          log_we.push_back(bus.mem_we);
          log_wdata.push_back(bus.mem_wdata);
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  // hold a request until the stall drops; returns stalled cycle count and values at release
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int stall_n,
                           output logic [31:0] rdata, output logic req_rel);
    bus.core_rd    = rd;
    bus.core_wr    = wr;
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
    stall_n = 0;
    rdata   = 'x;
    req_rel = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.core_stall) begin
        rdata   = bus.core_rdata;
        req_rel = bus.mem_req;
        break;
      end
      stall_n++;
    end
    @(posedge clk);
    #1;
    bus.core_rd = 1'b0;
    bus.core_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_b          = 1'b0;
    bus.core_rd    = 1'b0;
    bus.core_wr    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got req=%b we=%b want 0 0", bus.mem_req, bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.core_stall !== 1'b0 || bus.core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_core got stall=%b rdata=%h want 0 0", bus.core_stall, bus.core_rdata);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_fill(input string name, input logic [31:0] addr);
    int          n;
    logic [31:0] rd;
    logic        rq;
    clear_log();
    do_access(1'b1, 1'b0, addr, 32'h0, n, rd, rq);
    checks++;
    if (n !== 13) begin
      errors++;
      $display("FAIL %s_stall got %0d want 13", name, n);
    end
    checks++;
    if (rd !== addr) begin
      errors++;
      $display("FAIL %s_rdata got %h want %h", name, rd, addr);
    end
    checks++;
    if (log_addr.size() !== 4) begin
      errors++;
      $display("FAIL %s_xfers got %0d want 4", name, log_addr.size());
    end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== addr + 32'(4 * i) || log_we[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s_xfer%0d got addr=%h we=%b want %h 0", name, i, log_addr[i], log_we[i], addr + 32'(4 * i));
      end
    end
  endtask

  task automatic check_hit(input string name, input logic [31:0] addr, input logic [31:0] exp);
    int          n;
    logic [31:0] rd;
    logic        rq;
    clear_log();
    do_access(1'b1, 1'b0, addr, 32'h0, n, rd, rq);
    checks++;
    if (n !== 0 || rq !== 1'b0 || log_addr.size() !== 0) begin
      errors++;
      $display("FAIL %s_hit got stall=%0d req=%b xfers=%0d want 0 0 0", name, n, rq, log_addr.size());
    end
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s_rdata got %h want %h", name, rd, exp);
    end
  endtask

  task automatic check_write(input string name, input logic [31:0] addr, input logic [31:0] wd);
    int          n;
    logic [31:0] rd;
    logic        rq;
    clear_log();
    do_access(1'b0, 1'b1, addr, wd, n, rd, rq);
    checks++;
    if (n !== 4 || rq !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall got stall=%0d req=%b want 4 0", name, n, rq);
    end
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== addr || log_we[0] !== 1'b1 || log_wdata[0] !== wd) begin
      errors++;
      $display("FAIL %s_xfer got n=%0d addr=%h we=%b wdata=%h want 1 %h 1 %h",
               name, log_addr.size(), log_addr[0], log_we[0], log_wdata[0], addr, wd);
    end
  endtask

  task automatic test_read_miss();
    check_fill("miss100", 32'h100);
  endtask

  task automatic test_read_hit();
    check_hit("hit108", 32'h108, 32'h0000_0108);
  endtask

  task automatic test_write_hit();
    check_write("wr104", 32'h104, 32'hDEAD_BEEF);
    check_hit("rd104", 32'h104, 32'hDEAD_BEEF);
  endtask

  task automatic test_write_miss();
    check_write("wr400", 32'h400, 32'h1234_5678);
    check_hit("rd100_kept", 32'h100, 32'h0000_0100);
    check_fill("miss400", 32'h400);
  endtask

  task automatic test_conflict();
    check_fill("miss200", 32'h200);
    check_fill("remiss100", 32'h100);
    check_hit("rd104_refill", 32'h104, 32'h0000_0104);
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    clear_log();
    bus.core_rd   = 1'b1;
    bus.core_wr   = 1'b0;
    bus.core_addr = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #3;
      if (log_addr.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstfill_acks got %0d want 2", log_addr.size());
    end
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstfill_req got %b want 0", bus.mem_req);
    end
    bus.core_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    checks++;
    if (log_addr.size() !== 2) begin
      errors++;
      $display("FAIL rstfill_xfers got %0d want 2", log_addr.size());
    end
    @(posedge clk);
    #1;
    check_fill("rstfill100", 32'h100);
    check_fill("rstfill300", 32'h300);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
